matmul_stream_loader: RTL and testbench

Hardware front-end for `Matrix_Mul` that performs the load/collect sequence in logic. It accepts a 72-word frame on a valid/ready input stream: 64 matrix words in row-major order, then 8 vector words. It writes the frame into `Matrix_Mul` through its `we`/`addr`/`data_wr` port, samples the 8 `AB_Transpose` results with their `QI`/`QF` format, and replays them on a valid/ready output stream. It sits between the system-side data source/sink and `Matrix_Mul`.

---
 rtl/matmul_stream_loader_if.sv | 37 +++
 rtl/matmul_stream_loader.sv | 185 ++++++++++++++++++
 tb/tb_matmul_stream_loader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_stream_loader_if.sv
// Stream, Matrix_Mul write-port and result-port signals of the loader.
// slave: the loader's own view. master: the surrounding source, sink and Matrix_Mul.
interface matmul_stream_loader_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDRS_LEN = 7
);
  logic                        s_valid;
  logic [WORD_SIZE-1:0]        s_data;
  logic                        s_ready;
  logic                        mm_we;
  logic [ADDRS_LEN-1:0]        mm_addr;
  logic [WORD_SIZE-1:0]        mm_data_wr;
  logic signed [WORD_SIZE-1:0] mm_result;
  logic [3:0]                  mm_qi;
  logic [3:0]                  mm_qf;
  logic                        m_valid;
  logic [WORD_SIZE-1:0]        m_data;
  logic [3:0]                  m_qi;
  logic [3:0]                  m_qf;
  logic [2:0]                  m_index;
  logic                        m_last;
  logic                        m_ready;
  logic                        busy;
  logic                        frame_done;

  modport slave (
    input  s_valid, s_data, mm_result, mm_qi, mm_qf, m_ready,
    output s_ready, mm_we, mm_addr, mm_data_wr,
           m_valid, m_data, m_qi, m_qf, m_index, m_last, busy, frame_done
  );

  modport master (
    output s_valid, s_data, mm_result, mm_qi, mm_qf, m_ready,
    input  s_ready, mm_we, mm_addr, mm_data_wr,
           m_valid, m_data, m_qi, m_qf, m_index, m_last, busy, frame_done
  );
endinterface

// File: rtl/matmul_stream_loader.sv
// Loads one 72-word frame (64 matrix + 8 vector words) into Matrix_Mul,
// waits LAT cycles, captures the 8 AB_Transpose results with their
// QI/QF format, and replays them on a valid/ready output stream.
//
// state   | meaning
// LOAD    | accept input beats, write each into Matrix_Mul at its beat address
// SETTLE  | wait LAT cycles for Matrix_Mul to produce results
// CAPTURE | sample one result per cycle into buffer entries 0..7
// DRAIN   | present buffer entries 0..7 on the output stream
module matmul_stream_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDRS_LEN = 7,
  parameter int LAT       = 4
) (
  input  logic                   src_clk,
  input  logic                   rst,
  matmul_stream_loader_if.slave  bus
);

  typedef enum logic [1:0] {LOAD, SETTLE, CAPTURE, DRAIN} state_t;

  localparam logic [6:0] LAST_BEAT = 7'd71;
  localparam logic [3:0] LAT_C     = 4'(LAT);

  state_t               state_q, state_d;
  logic [6:0]           beat_q, beat_d;
  logic [3:0]           wait_q, wait_d;
  logic [2:0]           cap_q, cap_d;
  logic                 s_ready_q, s_ready_d;
  logic                 mm_we_q, mm_we_d;
  logic [ADDRS_LEN-1:0] mm_addr_q, mm_addr_d;
  logic [WORD_SIZE-1:0] mm_data_q, mm_data_d;
  logic                 m_valid_q, m_valid_d;
  logic [WORD_SIZE-1:0] m_data_q, m_data_d;
  logic [3:0]           m_qi_q, m_qi_d;
  logic [3:0]           m_qf_q, m_qf_d;
  logic [2:0]           m_index_q, m_index_d;
  logic                 m_last_q, m_last_d;

  logic [WORD_SIZE-1:0] res_buf_q [8];
  logic [3:0]           qi_buf_q  [8];
  logic [3:0]           qf_buf_q  [8];

  logic                 s_ready;
  logic                 in_hs;
  logic                 out_hs;
  logic [2:0]           nxt_idx;

  // s_ready is forced low during the reset cycle itself, not only after it
  assign s_ready = s_ready_q & ~rst;
  assign in_hs   = bus.s_valid & s_ready;
  assign out_hs  = m_valid_q & bus.m_ready;
  assign nxt_idx = m_index_q + 3'd1;

  // Next-state and next-output computation for the load/settle/capture/drain sequence
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    cap_d     = cap_q;
    mm_we_d   = 1'b0;
    mm_addr_d = mm_addr_q;
    mm_data_d = mm_data_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_qi_d    = m_qi_q;
    m_qf_d    = m_qf_q;
    m_index_d = m_index_q;
    m_last_d  = m_last_q;
    case (state_q)
      LOAD: begin
        if (in_hs) begin
          mm_we_d   = 1'b1;
          mm_addr_d = ADDRS_LEN'(beat_q);
          mm_data_d = bus.s_data;
          if (beat_q == LAST_BEAT) begin
            state_d = SETTLE;
            beat_d  = 7'd0;
            wait_d  = 4'd1;
          end else begin
            beat_d = beat_q + 7'd1;
          end
        end
      end
      SETTLE: begin
        if (wait_q == LAT_C) begin
          state_d = CAPTURE;
          wait_d  = 4'd0;
          cap_d   = 3'd0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      CAPTURE: begin
        cap_d = cap_q + 3'd1;
        if (cap_q == 3'd7) begin
          // entry 0 was written seven cycles ago, so it can be presented right away
          state_d   = DRAIN;
          m_valid_d = 1'b1;
          m_data_d  = res_buf_q[0];
          m_qi_d    = qi_buf_q[0];
          m_qf_d    = qf_buf_q[0];
          m_index_d = 3'd0;
          m_last_d  = 1'b0;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (m_index_q == 3'd7) begin
            state_d   = LOAD;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_index_d = 3'd0;
          end else begin
            m_index_d = nxt_idx;
            m_data_d  = res_buf_q[nxt_idx];
            m_qi_d    = qi_buf_q[nxt_idx];
            m_qf_d    = qf_buf_q[nxt_idx];
            m_last_d  = (nxt_idx == 3'd7);
          end
        end
      end
      default: state_d = LOAD;
    endcase
    s_ready_d = (state_d == LOAD);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q   <= LOAD;
      beat_q    <= 7'd0;
      wait_q    <= 4'd0;
      cap_q     <= 3'd0;
      s_ready_q <= 1'b0;
      mm_we_q   <= 1'b0;
      mm_addr_q <= '0;
      mm_data_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_qi_q    <= 4'd0;
      m_qf_q    <= 4'd0;
      m_index_q <= 3'd0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      cap_q     <= cap_d;
      s_ready_q <= s_ready_d;
      mm_we_q   <= mm_we_d;
      mm_addr_q <= mm_addr_d;
      mm_data_q <= mm_data_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_qi_q    <= m_qi_d;
      m_qf_q    <= m_qf_d;
      m_index_q <= m_index_d;
      m_last_q  <= m_last_d;
    end
  end

  // Result buffer; left uncleared on reset since stale entries are never presented
  always_ff @(posedge src_clk) begin
    if (state_q == CAPTURE) begin
      res_buf_q[cap_q] <= bus.mm_result;
      qi_buf_q[cap_q]  <= bus.mm_qi;
      qf_buf_q[cap_q]  <= bus.mm_qf;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.mm_we      = mm_we_q;
  assign bus.mm_addr    = mm_addr_q;
  assign bus.mm_data_wr = mm_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_qi       = m_qi_q;
  assign bus.m_qf       = m_qf_q;
  assign bus.m_index    = m_index_q;
  assign bus.m_last     = m_last_q;
  assign bus.busy       = !((state_q == LOAD) && (beat_q == 7'd0));
  assign bus.frame_done = out_hs & m_last_q;

endmodule

// File: tb/tb_matmul_stream_loader.sv
// Scoreboard bench for matmul_stream_loader: stimulus pushes expected writes
// and results into queues, monitors pop and compare as the DUT presents them.
module tb_matmul_stream_loader;
  localparam int WS  = 16;
  localparam int AL  = 7;
  localparam int LAT = 4;

  logic src_clk = 1'b0;
  logic rst     = 1'b1;

  matmul_stream_loader_if #(.WORD_SIZE(WS), .ADDRS_LEN(AL)) bus ();

  matmul_stream_loader #(.WORD_SIZE(WS), .ADDRS_LEN(AL), .LAT(LAT)) dut (
    .src_clk (src_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 src_clk = ~src_clk;

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  qi;
    logic [3:0]  qf;
    logic [2:0]  idx;
    logic        last;
  } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  wr_t  got_wr;
  res_t got_res;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_seen  = 0;
  int fd_count = 0;
  int ready_mode = 2;
  int pat_ptr = 0;
  bit pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  bit prev_stall = 1'b0;
  logic [31:0] snap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  // Output-ready driver
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge src_clk);
      #1;
      case (ready_mode)
        0: bus.m_ready = 1'b1;
        1: begin
          bus.m_ready = pat[pat_ptr];
          pat_ptr = (pat_ptr + 1) % 6;
        end
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Write-port monitor
  always @(negedge src_clk) begin
    if (bus.mm_we === 1'b1) begin
      wr_seen++;
      if (exp_wr.size() == 0) begin
        chk("write_unexpected_addr", 32'(bus.mm_addr), 32'hFFFF_FFFF);
      end else begin
        got_wr = exp_wr.pop_front();
        chk("mm_addr", 32'(bus.mm_addr), 32'(got_wr.addr));
        chk("mm_data_wr", 32'(bus.mm_data_wr), 32'(got_wr.data));
      end
    end
  end

  // Result-stream monitor
  always @(negedge src_clk) begin
    if (bus.frame_done === 1'b1) fd_count++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.m_valid), 32'd1);
        chk("stall_outputs", {4'd0, bus.m_data, bus.m_qi, bus.m_qf, bus.m_index, bus.m_last}, snap);
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        if (exp_res.size() == 0) begin
          chk("result_unexpected", 32'(bus.m_data), 32'hFFFF_FFFF);
        end else begin
          got_res = exp_res.pop_front();
          chk("m_data", 32'(bus.m_data), 32'(got_res.data));
          chk("m_qi", 32'(bus.m_qi), 32'(got_res.qi));
          chk("m_qf", 32'(bus.m_qf), 32'(got_res.qf));
          chk("m_index", 32'(bus.m_index), 32'(got_res.idx));
          chk("m_last", 32'(bus.m_last), 32'(got_res.last));
          chk("frame_done_on_hs", 32'(bus.frame_done), 32'(got_res.last));
        end
      end else if (bus.frame_done === 1'b1) begin
        chk("frame_done_spurious", 32'(bus.frame_done), 32'd0);
      end
      prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
      snap = {4'd0, bus.m_data, bus.m_qi, bus.m_qf, bus.m_index, bus.m_last};
    end
  end

  task automatic do_reset();
    @(posedge src_clk);
    #1;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    repeat (2) @(posedge src_clk);
    #1;
    rst = 1'b0;
    exp_res.delete();
    @(negedge src_clk);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_mm_we", 32'(bus.mm_we), 32'd0);
    chk("rst_mm_addr", 32'(bus.mm_addr), 32'd0);
    chk("rst_mm_data_wr", 32'(bus.mm_data_wr), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_m_qi", 32'(bus.m_qi), 32'd0);
    chk("rst_m_qf", 32'(bus.m_qf), 32'd0);
    chk("rst_m_index", 32'(bus.m_index), 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    @(negedge src_clk);
    chk("rst_s_ready_next", 32'(bus.s_ready), 32'd1);
  endtask

  task automatic send_beats(input int n, input logic [15:0] dbase, input bit gapped,
                            input bit keep, output int cyc);
    wr_t e;
    cyc = 0;
    @(posedge src_clk);
    #1;
    for (int i = 0; i < n; i++) begin
      bit rdy;
      int w;
      if (gapped && i > 0) begin
        bus.s_valid = 1'b0;
        @(posedge src_clk);
        #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = dbase + 16'(i);
      rdy = 1'b0;
      w = 0;
      while (!rdy && w < 300) begin
        @(negedge src_clk);
        rdy = bus.s_ready;
        @(posedge src_clk);
        w++;
        cyc++;
      end
      #1;
      if (!rdy) begin
        chk("s_ready_timeout", 32'(bus.s_ready), 32'd1);
        bus.s_valid = 1'b0;
        return;
      end
      e.addr = 7'(i);
      e.data = dbase + 16'(i);
      exp_wr.push_back(e);
    end
    if (keep) bus.s_data = 16'hBAD0;
    else bus.s_valid = 1'b0;
  endtask

  // Called just after the last beat is accepted; plays Matrix_Mul's result port
  task automatic do_capture(input logic [15:0] rbase, input bit varied);
    res_t r;
    bus.mm_result = 16'hDEAD;
    @(negedge src_clk);
    chk("s_ready_settle", 32'(bus.s_ready), 32'd0);
    chk("busy_settle", 32'(bus.busy), 32'd1);
    repeat (LAT) @(posedge src_clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      r.data = rbase + 16'(k);
      r.qi   = varied ? 4'(k) : 4'd3;
      r.qf   = varied ? 4'(15 - k) : 4'd12;
      r.idx  = 3'(k);
      r.last = (k == 7);
      bus.mm_result = r.data;
      bus.mm_qi = r.qi;
      bus.mm_qf = r.qf;
      exp_res.push_back(r);
      if (k == 7) begin
        @(negedge src_clk);
        chk("m_valid_before_rise", 32'(bus.m_valid), 32'd0);
      end
      @(posedge src_clk);
      #1;
    end
    bus.mm_result = 16'hDEAD;
    bus.mm_qi = 4'hF;
    bus.mm_qf = 4'hF;
    bus.s_valid = 1'b0;
    @(negedge src_clk);
    chk("m_valid_rise_lat_plus_9", 32'(bus.m_valid), 32'd1);
  endtask

  task automatic wait_done();
    int w = 0;
    do begin
      @(negedge src_clk);
      w++;
    end while (bus.frame_done !== 1'b1 && w < 400);
    chk("frame_done_seen", 32'(bus.frame_done), 32'd1);
  endtask

  task automatic end_frame(input string tag, input int fd0, input int w0, input int nwr);
    @(negedge src_clk);
    chk({tag, "_s_ready_after"}, 32'(bus.s_ready), 32'd1);
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({tag, "_results_left"}, 32'(exp_res.size()), 32'd0);
    chk({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    chk({tag, "_write_count"}, 32'(wr_seen - w0), 32'(nwr));
    chk({tag, "_frame_done_pulses"}, 32'(fd_count - fd0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, fd0, w0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.mm_result = '0;
    bus.mm_qi     = '0;
    bus.mm_qf     = '0;
    do_reset();

    // Frame A: continuous input, always-ready sink, fixed format
    ready_mode = 0;
    fd0 = fd_count; w0 = wr_seen;
    send_beats(72, 16'h0001, 1'b0, 1'b1, cyc);
    chk("continuous_accept_cycles", 32'(cyc), 32'd72);
    do_capture(16'h0100, 1'b0);
    repeat (7) @(negedge src_clk);
    chk("frame_done_at_lat_plus_16", 32'(bus.frame_done), 32'd1);
    end_frame("A", fd0, w0, 72);

    // Frame B: gapped input, backpressured sink, negative results, varied format
    ready_mode = 1;
    fd0 = fd_count; w0 = wr_seen;
    send_beats(72, 16'h1000, 1'b1, 1'b0, cyc);
    do_capture(16'h8200, 1'b1);
    wait_done();
    end_frame("B", fd0, w0, 72);

    // Frame C abandoned at beat 30, then frame D from scratch
    ready_mode = 0;
    w0 = wr_seen;
    send_beats(30, 16'h2000, 1'b0, 1'b0, cyc);
    @(negedge src_clk);
    chk("busy_mid_load", 32'(bus.busy), 32'd1);
    do_reset();
    chk("abandoned_write_count", 32'(wr_seen - w0), 32'd30);
    fd0 = fd_count; w0 = wr_seen;
    send_beats(72, 16'h3000, 1'b0, 1'b0, cyc);
    do_capture(16'h0300, 1'b0);
    wait_done();
    end_frame("D", fd0, w0, 72);

    // Frame E stalled in drain, reset mid-drain, then frame F
    ready_mode = 2;
    send_beats(72, 16'h4000, 1'b0, 1'b0, cyc);
    do_capture(16'h0400, 1'b1);
    repeat (3) @(negedge src_clk);
    chk("drain_stalled_valid", 32'(bus.m_valid), 32'd1);
    chk("drain_stalled_index", 32'(bus.m_index), 32'd0);
    do_reset();
    ready_mode = 0;
    fd0 = fd_count; w0 = wr_seen;
    send_beats(72, 16'h5000, 1'b0, 1'b0, cyc);
    do_capture(16'h0500, 1'b0);
    wait_done();
    end_frame("F", fd0, w0, 72);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
